// File: rtl/mont_exp_ctrl_pkg.sv
// Shared types and defaults for the modular exponentiation controller.
// State encoding of the square-and-multiply sequencer.
package mont_exp_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 1024;
    localparam int DEF_EXP_WIDTH  = 1024;
    localparam int DEF_LEN_WIDTH  = 11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MU_ISSUE,
        S_MU_WAIT,
        S_CV_ISSUE,
        S_CV_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation controller.
// Drives an external Montgomery multiplier via a start/done handshake.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_x_mont,
    input  logic [DATA_WIDTH-1:0] in_r_mod_m,
    input  logic [DATA_WIDTH-1:0] in_m,
    input  logic [EXP_WIDTH-1:0]  in_e,
    input  logic [LEN_WIDTH-1:0]  in_e_len,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  busy,
    output logic                  mm_start,
    output logic [DATA_WIDTH-1:0] mm_a,
    output logic [DATA_WIDTH-1:0] mm_b,
    output logic [DATA_WIDTH-1:0] mm_m,
    input  logic [DATA_WIDTH-1:0] mm_result,
    input  logic                  mm_done
);

    localparam logic [LEN_WIDTH-1:0] EXP_LEN = LEN_WIDTH'(EXP_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [EXP_WIDTH-1:0]  e_q, e_d;
    logic [LEN_WIDTH-1:0]  i_q, i_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  mm_start_q, mm_start_d;
    logic [DATA_WIDTH-1:0] mm_a_q, mm_a_d;
    logic [DATA_WIDTH-1:0] mm_b_q, mm_b_d;
    logic [DATA_WIDTH-1:0] mm_m_q, mm_m_d;

    logic [LEN_WIDTH-1:0]  len_sat;
    logic                  e_bit;
    logic                  mm_cap;

    assign len_sat = (in_e_len > EXP_LEN) ? EXP_LEN : in_e_len;
    assign e_bit   = |(e_q & (EXP_WIDTH'(1) << i_q));
    // A done seen while our own start is still high belongs to the previous op.
    assign mm_cap  = mm_done && !mm_start_q;

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = mm_m_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            x_q        <= '0;
            e_q        <= '0;
            i_q        <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            x_q        <= x_d;
            e_q        <= e_d;
            i_q        <= i_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_m_q     <= mm_m_d;
        end
    end

    // Next-state and next-register computation for the exponentiation sequence.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        x_d        = x_q;
        e_d        = e_q;
        i_d        = i_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_m_d     = mm_m_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = in_x_mont;
                    mm_m_d  = in_m;
                    e_d     = in_e;
                    i_d     = len_sat;
                    a_d     = in_r_mod_m;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_q == '0) begin
                    state_d = S_CV_ISSUE;
                end else begin
                    i_d     = i_q - 1'b1;
                    state_d = S_SQ_ISSUE;
                end
            end
            S_SQ_ISSUE: begin
                mm_a_d     = a_q;
                mm_b_d     = a_q;
                mm_start_d = 1'b1;
                state_d    = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm_cap) begin
                    a_d     = mm_result;
                    state_d = e_bit ? S_MU_ISSUE : S_CHECK;
                end
            end
            S_MU_ISSUE: begin
                mm_a_d     = a_q;
                mm_b_d     = x_q;
                mm_start_d = 1'b1;
                state_d    = S_MU_WAIT;
            end
            S_MU_WAIT: begin
                if (mm_cap) begin
                    a_d     = mm_result;
                    state_d = S_CHECK;
                end
            end
            S_CV_ISSUE: begin
                mm_a_d     = a_q;
                mm_b_d     = DATA_WIDTH'(1);
                mm_start_d = 1'b1;
                state_d    = S_CV_WAIT;
            end
            S_CV_WAIT: begin
                if (mm_cap) begin
                    result_d = mm_result;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery core.
// Expected results come from plain modular arithmetic on small moduli.
module tb_mont_exp_ctrl;

    localparam int DW = 8;
    localparam int EW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_x_mont = '0;
    logic [DW-1:0] in_r_mod_m = '0;
    logic [DW-1:0] in_m = '0;
    logic [EW-1:0] in_e = '0;
    logic [LW-1:0] in_e_len = '0;
    logic [DW-1:0] result;
    logic          done;
    logic          busy;
    logic          mm_start;
    logic [DW-1:0] mm_a;
    logic [DW-1:0] mm_b;
    logic [DW-1:0] mm_m;
    logic [DW-1:0] mm_result = '0;
    logic          mm_done = 1'b0;

    mont_exp_ctrl #(
        .DATA_WIDTH(DW),
        .EXP_WIDTH (EW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x_mont (in_x_mont),
        .in_r_mod_m(in_r_mod_m),
        .in_m      (in_m),
        .in_e      (in_e),
        .in_e_len  (in_e_len),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // a*b*R^-1 mod m with R = 256, by search (m is odd and small)
    function automatic int mont(input int a, input int b, input int m);
        int p;
        if (m <= 1) return 0;
        p = (a * b) % m;
        for (int t = 0; t < m; t++)
            if ((t * 256) % m == p) return t;
        return 0;
    endfunction

    int q_a[$];
    int q_b[$];
    int exp_m = 0;
    int exp_res = 0;
    int n_starts = 0;
    int n_done = 0;
    int core_hold = 1;

    // Behavioural core: random latency, done held core_hold cycles.
    int ca, cb, cm, c_lat, c_hold;
    bit c_busy;
    always @(negedge clk) begin
        if (!resetn) begin
            c_busy = 0;
            c_hold = 0;
            mm_done = 1'b0;
            mm_result = '0;
        end else begin
            if (c_hold > 0) begin
                c_hold--;
                if (c_hold == 0) mm_done = 1'b0;
            end
            if (mm_start) begin
                ca = int'(mm_a);
                cb = int'(mm_b);
                cm = int'(mm_m);
                c_lat = $urandom_range(1, 20);
                c_busy = 1;
            end else if (c_busy) begin
                c_lat--;
                if (c_lat == 0) begin
                    c_busy = 0;
                    mm_done = 1'b1;
                    mm_result = DW'(mont(ca, cb, cm));
                    c_hold = core_hold;
                end
            end
        end
    end

    // Per-cycle compare, sampled 1 time unit after each rising edge.
    int cyc = 0;
    int st_cyc = 0;
    int cap_cyc = -10;
    bit running = 0;
    bit done_prev = 0;
    bit outst = 0;
    logic [DW-1:0] oa, ob, om;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!resetn) begin
            running = 0;
            done_prev = 0;
            outst = 0;
            cap_cyc = -10;
        end else begin
            if (outst && mm_done && cyc >= st_cyc + 2) begin
                outst = 0;
                cap_cyc = cyc;
            end
            if (outst)
                chk("operand_hold", {mm_a, mm_b, mm_m}, {oa, ob, om});
            if (mm_start) begin
                chk("start_while_outstanding", outst, 0);
                chk("start_gap_after_capture", cyc > cap_cyc, 1);
                chk("op_expected", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    chk("mm_a", mm_a, q_a.pop_front());
                    chk("mm_b", mm_b, q_b.pop_front());
                    chk("mm_m", mm_m, exp_m);
                end
                n_starts++;
                outst = 1;
                st_cyc = cyc;
                oa = mm_a;
                ob = mm_b;
                om = mm_m;
            end
            if (start && !running && !done_prev) running = 1;
            if (done) begin
                chk("done_single_cycle", done_prev, 0);
                chk("result_at_done", result, exp_res);
                chk("busy_at_done", busy, 0);
                chk("done_in_run", running, 1);
                n_done++;
                running = 0;
            end else begin
                chk("busy", busy, running);
            end
            done_prev = done;
        end
    end

    int p_ops;

    // Build the expected operation list and result for one exponentiation.
    task automatic prep(input string nm, input int x, input int m,
                        input int e, input int len, input int hold,
                        input int lit_res, input int lit_ops,
                        input int lit_a0, input int lit_b0);
        int r, xm, ln, a, res, pc;
        r = 256 % m;
        xm = (x * 256) % m;
        ln = (len > EW) ? EW : len;
        res = 1 % m;
        pc = 0;
        for (int j = ln - 1; j >= 0; j--) begin
            res = (res * res) % m;
            if (((e >> j) & 1) == 1) begin
                res = (res * x) % m;
                pc++;
            end
        end
        q_a.delete();
        q_b.delete();
        a = r;
        for (int j = ln - 1; j >= 0; j--) begin
            q_a.push_back(a);
            q_b.push_back(a);
            a = mont(a, a, m);
            if (((e >> j) & 1) == 1) begin
                q_a.push_back(a);
                q_b.push_back(xm);
                a = mont(a, xm, m);
            end
        end
        q_a.push_back(a);
        q_b.push_back(1);
        p_ops = ln + pc + 1;
        if (lit_res >= 0) chk({nm, "_model_result"}, res, lit_res);
        if (lit_ops >= 0) chk({nm, "_model_ops"}, p_ops, lit_ops);
        if (lit_a0 >= 0) chk({nm, "_model_first_a"}, q_a[0], lit_a0);
        if (lit_b0 >= 0) chk({nm, "_model_first_b"}, q_b[0], lit_b0);
        chk({nm, "_model_seq_len"}, q_a.size(), p_ops);
        exp_res = res;
        exp_m = m;
        core_hold = hold;
        n_starts = 0;
        n_done = 0;
        @(negedge clk);
        in_x_mont = DW'(xm);
        in_r_mod_m = DW'(r);
        in_m = DW'(m);
        in_e = EW'(e);
        in_e_len = LW'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_x_mont = DW'($urandom);
        in_r_mod_m = DW'($urandom);
        in_m = DW'($urandom);
        in_e = EW'($urandom);
        in_e_len = LW'($urandom);
    endtask

    task automatic run(input string nm, input int x, input int m,
                       input int e, input int len, input int hold,
                       input int lit_res, input int lit_ops,
                       input int lit_a0, input int lit_b0,
                       input bit mid_start, input bit poke_done);
        bit got;
        prep(nm, x, m, e, len, hold, lit_res, lit_ops, lit_a0, lit_b0);
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            start = (mid_start && c == 5);
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, got, 1);
        if (got && poke_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk({nm, "_op_count"}, n_starts, p_ops);
        chk({nm, "_done_count"}, n_done, 1);
        chk({nm, "_result_held"}, result, exp_res);
        chk({nm, "_idle_busy"}, busy, 0);
        if (!got) begin
            resetn = 1'b0;
            repeat (2) @(negedge clk);
            resetn = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {result, done, busy, mm_start, mm_a, mm_b, mm_m}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // x=2 mod 11: 2^10 = 1, 4 squarings + 2 multiplies + 1 conversion
        run("t1", 2, 11, 10, 4, 1, 1, 7, 3, 3, 0, 0);
        // 2^3 = 8; start during the done cycle must be ignored
        run("t2", 2, 11, 3, 2, 1, 8, 5, 3, 3, 0, 1);
        // empty exponent: single conversion op (3, 1)
        run("t3", 2, 11, 10, 0, 1, 1, 1, 3, 1, 0, 0);
        // core holds done for 3 cycles
        run("t4", 2, 11, 10, 4, 3, 1, 7, 3, 3, 0, 0);
        // restart request mid-run is ignored
        run("t5a", 2, 11, 10, 4, 2, 1, 7, 3, 3, 1, 0);
        // length 15 saturates to 8: 2^0x85 mod 13 = 2
        run("sat", 2, 13, 'h85, 15, 1, 2, 12, 9, 9, 0, 0);

        // reset in the middle of a run
        prep("t5b", 2, 11, 10, 4, 1, 1, 7, 3, 3);
        repeat (20) @(negedge clk);
        chk("t5b_busy_before_reset", busy, 1);
        resetn = 1'b0;
        #1;
        chk("t5b_outputs_in_reset",
            {result, done, busy, mm_start, mm_a, mm_b, mm_m}, 0);
        @(negedge clk);
        chk("t5b_outputs_next_cycle",
            {result, done, busy, mm_start, mm_a, mm_b, mm_m}, 0);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run("t5c", 2, 11, 10, 4, 1, 1, 7, 3, 3, 0, 0);

        for (int k = 0; k < 6; k++) begin
            int m, x, e, len, hold;
            m = $urandom_range(3, 255) | 1;
            x = $urandom_range(0, m - 1);
            e = $urandom_range(0, 255);
            len = $urandom_range(0, 8);
            hold = $urandom_range(1, 3);
            run("rnd", x, m, e, len, hold, -1, -1, -1, -1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
